// File: rtl/mpmc11_strm_read_sequencer.sv
// rtl/mpmc11_strm_read_sequencer.sv - issues per-strip memory reads for one stream and writes returns to the read FIFO
// Optional feature macro MPMC11_STRM_RD_WRAP_EN adds req_wrap_mask for a circular address window.
module mpmc11_strm_read_sequencer #(
   parameter int DATA_W      = 256,
   parameter int STRIP_BYTES = 32,
   parameter int MAX_OUTST   = 8,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_adr,
   input  logic [CNT_W-1:0]  req_nstrips,
`ifdef MPMC11_STRM_RD_WRAP_EN
   input  logic [31:0]       req_wrap_mask,
`endif
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic [31:0]       mem_cmd_adr,
   input  logic              mem_rd_valid,
   input  logic [DATA_W-1:0] mem_rd_dat,
   input  logic              fifo_afull,
   output logic              wr,
   output logic [31:0]       wadr,
   output logic [DATA_W-1:0] wdat,
   output logic              last_strip
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   localparam logic [31:0] STRIP = 32'(STRIP_BYTES);
   localparam logic [7:0]  MAX_O = 8'(MAX_OUTST);

   state_t              state_q, state_d;
   logic [31:0]         iss_adr_q, iss_adr_d, ret_adr_q, ret_adr_d;
   logic [CNT_W-1:0]    iss_left_q, iss_left_d, ret_left_q, ret_left_d;
   logic [7:0]          outst_q, outst_d;
   logic                pend_q, pend_d, aborted_q, aborted_d;
   logic                wr_q, wr_d, last_q, last_d;
   logic [31:0]         wadr_q, wadr_d;
   logic [DATA_W-1:0]   wdat_q, wdat_d;
   logic                accept, abort_now, cmd_valid, cmd_hs, rd_acc;
   logic [31:0]         win_mask;

`ifdef MPMC11_STRM_RD_WRAP_EN
   logic [31:0] mask_q, mask_d;
   assign mask_d   = accept ? req_wrap_mask : mask_q;
   assign win_mask = mask_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mask_q <= '0;
      else        mask_q <= mask_d;
   end
`else
   assign win_mask = 32'hFFFF_FFFF;
`endif

   // Bits outside the mask are frozen, so the address circulates inside the window.
   function automatic logic [31:0] adv(input logic [31:0] a, input logic [31:0] m);
      return (a & ~m) | ((a + STRIP) & m);
   endfunction

   assign accept    = (state_q == S_IDLE) && req_valid;
   assign abort_now = abort && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
   // A pending command stays valid regardless of afull/outstanding until the controller takes it.
   assign cmd_valid = (state_q == S_ISSUE) && !abort &&
                      (pend_q || ((iss_left_q != '0) && (outst_q < MAX_O) && !fifo_afull));
   assign cmd_hs    = cmd_valid && mem_cmd_ready;
   assign rd_acc    = mem_rd_valid && (state_q != S_IDLE) && (outst_q != 8'd0);

   always_comb begin
      state_d    = state_q;
      iss_adr_d  = iss_adr_q;
      ret_adr_d  = ret_adr_q;
      iss_left_d = iss_left_q;
      ret_left_d = ret_left_q;
      aborted_d  = aborted_q;
      pend_d     = cmd_valid && !mem_cmd_ready;
      outst_d    = outst_q + {7'b0, cmd_hs} - {7'b0, rd_acc};
      wr_d       = 1'b0;
      last_d     = 1'b0;
      wadr_d     = wadr_q;
      wdat_d     = wdat_q;

      if (cmd_hs) begin
         iss_adr_d  = adv(iss_adr_q, win_mask);
         iss_left_d = iss_left_q - CNT_W'(1);
      end

      if (rd_acc) begin
         ret_left_d = ret_left_q - CNT_W'(1);
         ret_adr_d  = adv(ret_adr_q, win_mask);
         if (!aborted_q && !abort_now) begin
            wr_d   = 1'b1;
            wadr_d = ret_adr_q;
            wdat_d = mem_rd_dat;
            last_d = (ret_left_q == CNT_W'(1));
         end
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               iss_adr_d  = req_adr;
               ret_adr_d  = req_adr;
               iss_left_d = req_nstrips;
               ret_left_d = req_nstrips;
               aborted_d  = 1'b0;
               state_d    = (req_nstrips == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: if (iss_left_d == '0) state_d = S_DRAIN;
         S_DRAIN: if (ret_left_q == '0) state_d = aborted_q ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase

      // Aborted streams keep counting the reads still in flight so they can be swallowed.
      if (abort_now) begin
         state_d    = S_DRAIN;
         iss_left_d = '0;
         ret_left_d = CNT_W'(outst_q - {7'b0, rd_acc});
         aborted_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         iss_adr_q  <= '0;
         ret_adr_q  <= '0;
         iss_left_q <= '0;
         ret_left_q <= '0;
         outst_q    <= '0;
         pend_q     <= 1'b0;
         aborted_q  <= 1'b0;
         wr_q       <= 1'b0;
         last_q     <= 1'b0;
         wadr_q     <= '0;
         wdat_q     <= '0;
      end else begin
         state_q    <= state_d;
         iss_adr_q  <= iss_adr_d;
         ret_adr_q  <= ret_adr_d;
         iss_left_q <= iss_left_d;
         ret_left_q <= ret_left_d;
         outst_q    <= outst_d;
         pend_q     <= pend_d;
         aborted_q  <= aborted_d;
         wr_q       <= wr_d;
         last_q     <= last_d;
         wadr_q     <= wadr_d;
         wdat_q     <= wdat_d;
      end
   end

   assign req_ready     = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign mem_cmd_valid = cmd_valid;
   assign mem_cmd_adr   = iss_adr_q;
   assign wr            = wr_q;
   assign wadr          = wadr_q;
   assign wdat          = wdat_q;
   assign last_strip    = last_q;

endmodule
